// File: rtl/audio_pkg.sv
// Shared types for the I2S DAC transmit path.
// No logic: constants and enums only.
// Not applicable: no handshakes in a package.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } i2s_state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_t;

endpackage

// File: rtl/audio_i2s_tx_fifo.sv
// Per-channel show-ahead sample FIFO with a registered occupancy count.
// Latency: a pushed word is readable on o_pop_dat the cycle after the push edge.
// Backpressure: o_full is derived from the registered count only; a push into a full FIFO is dropped even with a same-cycle pop.
module sample_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_dat,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_dat,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S DAC transmitter: two Avalon-ST sinks into per-channel FIFOs, serialized MSB-first on DACDAT.
// Latency: pin BCLK edge to internal event 3 clk; BCLK fall to DACDAT change 4 clk.
// Backpressure: *_in_ready = FIFO not full; one pop per detected LRCK edge, empty pop sends silence and pulses underrun.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int DATA_W     = SAMPLE_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] left_in_data,
    input  logic              left_in_valid,
    output logic              left_in_ready,
    input  logic [DATA_W-1:0] right_in_data,
    input  logic              right_in_valid,
    output logic              right_in_ready,
    input  logic              aud_bclk,
    input  logic              aud_daclrck,
    output logic              aud_dacdat,
    output logic              underrun
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [2:0]        r_bclk_sync;
    logic [1:0]        r_lrck_sync;
    chan_t             r_lrck_prev;
    i2s_state_t        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CW-1:0]     r_bitcnt;
    logic              r_bit;
    logic              r_dacdat;

    logic              w_bclk_rise;
    logic              w_bclk_fall;
    chan_t             w_lrck_chan;
    logic              w_l_full;
    logic              w_l_empty;
    logic              w_r_full;
    logic              w_r_empty;
    logic [DATA_W-1:0] w_l_dat;
    logic [DATA_W-1:0] w_r_dat;

    i2s_state_t        w_state_nxt;
    chan_t             w_lrck_prev_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CW-1:0]     w_bitcnt_nxt;
    logic              w_bit_nxt;
    logic              w_pop_l;
    logic              w_pop_r;
    logic              w_underrun;

    sample_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_l (
        .clk        (clk),
        .rst_n      (reset),
        .i_push     (left_in_valid),
        .i_push_dat (left_in_data),
        .i_pop      (w_pop_l),
        .o_pop_dat  (w_l_dat),
        .o_full     (w_l_full),
        .o_empty    (w_l_empty)
    );

    sample_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_r (
        .clk        (clk),
        .rst_n      (reset),
        .i_push     (right_in_valid),
        .i_push_dat (right_in_data),
        .i_pop      (w_pop_r),
        .o_pop_dat  (w_r_dat),
        .o_full     (w_r_full),
        .o_empty    (w_r_empty)
    );

    assign left_in_ready  = !w_l_full;
    assign right_in_ready = !w_r_full;
    assign w_bclk_rise    = r_bclk_sync[1] && !r_bclk_sync[2];
    assign w_bclk_fall    = !r_bclk_sync[1] && r_bclk_sync[2];
    assign w_lrck_chan    = chan_t'(r_lrck_sync[1]);
    assign aud_dacdat     = r_dacdat;
    assign underrun       = w_underrun;

    // Word-clock edges take priority and may cut a word short mid-SHIFT.
    always_comb begin
        w_state_nxt     = r_state;
        w_lrck_prev_nxt = r_lrck_prev;
        w_shift_nxt     = r_shift;
        w_bitcnt_nxt    = r_bitcnt;
        w_bit_nxt       = r_bit;
        w_pop_l         = 1'b0;
        w_pop_r         = 1'b0;
        w_underrun      = 1'b0;
        if (w_bclk_rise && (w_lrck_chan != r_lrck_prev)) begin
            w_lrck_prev_nxt = w_lrck_chan;
            w_state_nxt     = ARMED;
            if (w_lrck_chan == RIGHT) begin
                w_pop_r     = 1'b1;
                w_underrun  = w_r_empty;
                w_shift_nxt = w_r_empty ? '0 : w_r_dat;
            end else begin
                w_pop_l     = 1'b1;
                w_underrun  = w_l_empty;
                w_shift_nxt = w_l_empty ? '0 : w_l_dat;
            end
        end else if (w_bclk_fall) begin
            unique case (r_state)
                IDLE: begin
                    w_bit_nxt = 1'b0;
                end
                ARMED: begin
                    w_bit_nxt    = r_shift[DATA_W-1];
                    w_shift_nxt  = r_shift << 1;
                    w_bitcnt_nxt = CW'(DATA_W-1);
                    w_state_nxt  = SHIFT;
                end
                SHIFT: begin
                    if (r_bitcnt != '0) begin
                        w_bit_nxt    = r_shift[DATA_W-1];
                        w_shift_nxt  = r_shift << 1;
                        w_bitcnt_nxt = r_bitcnt - 1'b1;
                    end else begin
                        w_bit_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_bit_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_lrck_prev <= LEFT;
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_bit       <= 1'b0;
            r_dacdat    <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[1:0], aud_bclk};
            r_lrck_sync <= {r_lrck_sync[0], aud_daclrck};
            r_lrck_prev <= w_lrck_prev_nxt;
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_bit       <= w_bit_nxt;
            r_dacdat    <= r_bit;
        end
    end

endmodule
